// File: rtl/spi_flash_responder_if.sv
// rtl/spi_flash_responder_if.sv - SPI pins between the flash command sequencer and the flash responder
interface spi_flash_responder_if;
  logic SCK;
  logic CSbar;
  logic DI;
  logic DO;

  modport master (output SCK, output CSbar, output DI, input DO);
  modport slave  (input SCK, input CSbar, input DI, output DO);
endinterface

// File: rtl/spi_flash_responder.sv
// rtl/spi_flash_responder.sv - serial NOR flash model, oversamples SCK in the clk domain
module spi_flash_responder #(
  parameter int          MEM_DEPTH   = 256,
  parameter int          ADDR_BITS   = 8,
  parameter int          PROG_CYCLES = 64,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4018
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_flash_responder_if.slave spi,
  output logic                 busy,
  output logic                 wel,
  output logic [7:0]           last_cmd
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, READ, PROG, STATUS, ID, IGNORE} state_t;

  localparam int                   TW        = $clog2(PROG_CYCLES + 1);
  localparam logic [ADDR_BITS-1:0] A_ONE     = ADDR_BITS'(1);
  localparam logic [ADDR_BITS-1:0] A_LAST    = ADDR_BITS'(MEM_DEPTH - 1);
  localparam logic [ADDR_BITS-1:0] PAGE_MASK = ADDR_BITS'(255);
  localparam logic [TW-1:0]        T_ONE     = TW'(1);
  localparam logic [TW-1:0]        T_LOAD    = TW'(PROG_CYCLES);

  logic [7:0] mem [MEM_DEPTH];

  state_t               state;
  logic [1:0]           sck_s, cs_s, di_s;
  logic                 sck_q, cs_q;
  logic [6:0]           sr;
  logic [2:0]           bit_cnt;
  logic [1:0]           byte_cnt;
  logic [15:0]          addr_sr;
  logic [ADDR_BITS-1:0] ptr;
  logic [7:0]           tx;
  logic [1:0]           id_idx;
  logic                 is_prog, prog_any;
  logic                 wren_arm, wrdi_arm, erase_arm;
  logic                 erase_active;
  logic [ADDR_BITS-1:0] erase_addr;
  logic [TW-1:0]        prog_timer;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_wa;
  logic [7:0]           mem_wd;

  logic                 sck_rise, sck_fall, cs_rise, byte_done;
  logic [7:0]           rx_byte, rd_data;
  logic [ADDR_BITS-1:0] rd_addr, ptr_page_next;

  assign sck_rise      = sck_s[1] & ~sck_q;
  assign sck_fall      = ~sck_s[1] & sck_q;
  assign cs_rise       = cs_s[1] & ~cs_q;
  assign rx_byte       = {sr, di_s[1]};
  assign byte_done     = sck_rise && (bit_cnt == 3'd7);
  // In ADDR the read port looks at the address completing this cycle so READ can preload byte 0.
  assign rd_addr       = (state == ADDR) ? ADDR_BITS'({addr_sr, rx_byte}) : ptr;
  assign rd_data       = mem[rd_addr];
  assign ptr_page_next = (ptr & ~PAGE_MASK) | ((ptr + A_ONE) & PAGE_MASK);

  always_ff @(posedge clk) begin
    if (erase_active) mem[erase_addr] <= 8'hFF;
    else if (mem_we)  mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_s        <= 2'b00;
      cs_s         <= 2'b11;
      di_s         <= 2'b00;
      sck_q        <= 1'b0;
      cs_q         <= 1'b1;
      state        <= IDLE;
      sr           <= '0;
      bit_cnt      <= '0;
      byte_cnt     <= '0;
      addr_sr      <= '0;
      ptr          <= '0;
      tx           <= '0;
      id_idx       <= '0;
      is_prog      <= 1'b0;
      prog_any     <= 1'b0;
      wren_arm     <= 1'b0;
      wrdi_arm     <= 1'b0;
      erase_arm    <= 1'b0;
      erase_active <= 1'b0;
      erase_addr   <= '0;
      prog_timer   <= '0;
      mem_we       <= 1'b0;
      mem_wa       <= '0;
      mem_wd       <= '0;
      spi.DO       <= 1'b0;
      busy         <= 1'b0;
      wel          <= 1'b0;
      last_cmd     <= 8'h00;
    end else begin
      sck_s  <= {sck_s[0], spi.SCK};
      cs_s   <= {cs_s[0], spi.CSbar};
      di_s   <= {di_s[0], spi.DI};
      sck_q  <= sck_s[1];
      cs_q   <= cs_s[1];
      mem_we <= 1'b0;

      // Erase sweep and program timer run independently of the serial front end.
      if (erase_active) begin
        erase_addr <= erase_addr + A_ONE;
        if (erase_addr == A_LAST) begin
          erase_active <= 1'b0;
          busy         <= 1'b0;
          wel          <= 1'b0;
        end
      end
      if (prog_timer != '0) begin
        prog_timer <= prog_timer - T_ONE;
        if (prog_timer == T_ONE) begin
          busy <= 1'b0;
          wel  <= 1'b0;
        end
      end

      if (cs_rise) begin
        state     <= IDLE;
        bit_cnt   <= '0;
        sr        <= '0;
        spi.DO    <= 1'b0;
        wren_arm  <= 1'b0;
        wrdi_arm  <= 1'b0;
        erase_arm <= 1'b0;
        if (wren_arm) wel <= 1'b1;
        if (wrdi_arm) wel <= 1'b0;
        if (state == PROG && prog_any && wel) begin
          prog_timer <= T_LOAD;
          busy       <= 1'b1;
        end
        if (erase_arm && wel) begin
          erase_active <= 1'b1;
          erase_addr   <= '0;
          busy         <= 1'b1;
        end
      end else begin
        if (sck_rise && state != IDLE) begin
          sr      <= rx_byte[6:0];
          bit_cnt <= bit_cnt + 3'd1;
        end
        case (state)
          IDLE: if (!cs_s[1]) state <= CMD;
          CMD: if (byte_done) begin
            last_cmd <= rx_byte;
            byte_cnt <= '0;
            prog_any <= 1'b0;
            if (busy && rx_byte != 8'h05) state <= IGNORE;
            else begin
              case (rx_byte)
                8'h06: begin wren_arm <= 1'b1; state <= IGNORE; end
                8'h04: begin wrdi_arm <= 1'b1; state <= IGNORE; end
                8'h05: begin tx <= {6'b0, wel, busy}; state <= STATUS; end
                8'h9F: begin tx <= JEDEC_ID[23:16]; id_idx <= 2'd1; state <= ID; end
                8'h03: begin is_prog <= 1'b0; state <= ADDR; end
                8'h02: begin is_prog <= 1'b1; state <= ADDR; end
                8'hC7: begin erase_arm <= 1'b1; state <= IGNORE; end
                default: state <= IGNORE;
              endcase
            end
          end
          ADDR: if (byte_done) begin
            addr_sr  <= {addr_sr[7:0], rx_byte};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd2) begin
              if (is_prog) begin
                ptr   <= rd_addr;
                state <= PROG;
              end else begin
                tx    <= rd_data;
                ptr   <= rd_addr + A_ONE;
                state <= READ;
              end
            end
          end
          READ, STATUS, ID: begin
            if (byte_done) begin
              if (state == READ) begin
                tx  <= rd_data;
                ptr <= ptr + A_ONE;
              end else if (state == STATUS) begin
                tx <= {6'b0, wel, busy};
              end else begin
                case (id_idx)
                  2'd1:    tx <= JEDEC_ID[15:8];
                  2'd2:    tx <= JEDEC_ID[7:0];
                  default: tx <= 8'h00;
                endcase
                if (id_idx != 2'd3) id_idx <= id_idx + 2'd1;
              end
            end else if (sck_fall) begin
              spi.DO <= tx[7];
              tx     <= {tx[6:0], 1'b0};
            end
          end
          PROG: if (byte_done && wel) begin
            mem_we   <= 1'b1;
            mem_wa   <= ptr;
            mem_wd   <= rd_data & rx_byte;
            ptr      <= ptr_page_next;
            prog_any <= 1'b1;
          end
          // Any bit past the opcode means chip erase was not exactly 8 bits.
          IGNORE: if (sck_rise) erase_arm <= 1'b0;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_flash_responder.sv
// tb/tb_spi_flash_responder.sv - directed vector bench for spi_flash_responder
module tb_spi_flash_responder;
  logic       clk = 1'b0;
  logic       rst;
  logic       busy, wel;
  logic [7:0] last_cmd;

  spi_flash_responder_if spi();

  spi_flash_responder dut (
    .clk(clk), .rst(rst), .spi(spi),
    .busy(busy), .wel(wel), .last_cmd(last_cmd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  op;
    logic        has_addr;
    logic [23:0] addr;
    int          n;
    int          extra;
    logic [31:0] txd;
    logic        chk_rx;
    logic [31:0] expd;
    int          busy_len;   // >=0 exact busy cycles, -1 wait idle, -2 expect still busy
    logic        exp_wel;
  } vec_t;

  vec_t vq[$];
  int   ntests = 0;
  int   nfail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic [7:0] op, input logic ha, input logic [23:0] addr,
                              input int n, input int extra, input logic [31:0] txd,
                              input logic chk, input logic [31:0] expd, input int blen,
                              input logic w);
    vec_t v;
    v.op = op; v.has_addr = ha; v.addr = addr; v.n = n; v.extra = extra;
    v.txd = txd; v.chk_rx = chk; v.expd = expd; v.busy_len = blen; v.exp_wel = w;
    vq.push_back(v);
  endfunction

  task automatic sck_bit(input logic b, output logic r);
    spi.DI = b;
    repeat (4) @(negedge clk);
    r = spi.DO;
    spi.SCK = 1'b1;
    repeat (4) @(negedge clk);
    spi.SCK = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic [7:0] r);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      sck_bit(d[i], b);
      r[i] = b;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [7:0] r;
    logic       b;
    int         cnt;
    logic       seen;
    spi.CSbar = 1'b0;
    repeat (4) @(negedge clk);
    send_byte(v.op, r);
    if (v.has_addr) begin
      send_byte(v.addr[23:16], r);
      send_byte(v.addr[15:8], r);
      send_byte(v.addr[7:0], r);
    end
    for (int k = 0; k < v.n; k++) begin
      send_byte(v.txd[31-8*k -: 8], r);
      if (v.chk_rx) check($sformatf("v%0d rx byte %0d", idx, k), {24'h0, r}, {24'h0, v.expd[31-8*k -: 8]});
    end
    for (int k = 0; k < v.extra; k++) sck_bit(1'b0, b);
    repeat (4) @(negedge clk);
    spi.CSbar = 1'b1;
    if (v.busy_len == -2) begin
      repeat (8) @(negedge clk);
      check($sformatf("v%0d busy held", idx), {31'h0, busy}, 32'h1);
    end else begin
      cnt  = 0;
      seen = 1'b0;
      for (int c = 0; c < 2000; c++) begin
        @(negedge clk);
        if (busy) begin
          cnt++;
          seen = 1'b1;
        end else if (seen || c >= 20) begin
          break;
        end
      end
      if (v.busy_len >= 0) check($sformatf("v%0d busy cycles", idx), cnt, v.busy_len);
      check($sformatf("v%0d busy idle", idx), {31'h0, busy}, 32'h0);
    end
    check($sformatf("v%0d last_cmd", idx), {24'h0, last_cmd}, {24'h0, v.op});
    check($sformatf("v%0d wel", idx), {31'h0, wel}, {31'h0, v.exp_wel});
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    vec_t       fin;

    //   op     addr    addr  n  ex txd            chk expd           busy  wel
    add(8'h9F, 1'b0, 24'h0,  3, 0, 32'h0,        1, 32'hEF401800, 0,    0);
    add(8'h06, 1'b0, 24'h0,  0, 0, 32'h0,        0, 32'h0,        0,    1);
    add(8'h05, 1'b0, 24'h0,  2, 0, 32'h0,        1, 32'h02020000, 0,    1);
    add(8'h04, 1'b0, 24'h0,  0, 0, 32'h0,        0, 32'h0,        0,    0);
    add(8'hC7, 1'b0, 24'h0,  0, 0, 32'h0,        0, 32'h0,        0,    0);
    add(8'h06, 1'b0, 24'h0,  0, 0, 32'h0,        0, 32'h0,        0,    1);
    add(8'hC7, 1'b0, 24'h0,  0, 0, 32'h0,        0, 32'h0,        256,  0);
    add(8'h03, 1'b1, 24'h10, 3, 0, 32'h0,        1, 32'hFFFFFF00, 0,    0);
    add(8'h06, 1'b0, 24'h0,  0, 0, 32'h0,        0, 32'h0,        0,    1);
    add(8'h02, 1'b1, 24'hFE, 3, 0, 32'hA53C7700, 0, 32'h0,        64,   0);
    add(8'h03, 1'b1, 24'hFD, 4, 0, 32'h0,        1, 32'hFFA53C77, 0,    0);
    add(8'h02, 1'b1, 24'h20, 1, 0, 32'h0,        0, 32'h0,        0,    0);
    add(8'h03, 1'b1, 24'h20, 1, 0, 32'h0,        1, 32'hFF000000, 0,    0);
    add(8'h06, 1'b0, 24'h0,  0, 0, 32'h0,        0, 32'h0,        0,    1);
    add(8'hC7, 1'b0, 24'h0,  0, 0, 32'h0,        0, 32'h0,        -2,   1);
    add(8'h05, 1'b0, 24'h0,  2, 0, 32'h0,        1, 32'h03030000, -1,   0);
    add(8'h06, 1'b0, 24'h0,  0, 0, 32'h0,        0, 32'h0,        0,    1);
    add(8'hC7, 1'b0, 24'h0,  0, 0, 32'h0,        0, 32'h0,        -2,   1);
    add(8'h03, 1'b1, 24'hFE, 1, 0, 32'h0,        1, 32'h00000000, -1,   0);
    add(8'h03, 1'b1, 24'hFE, 1, 0, 32'h0,        1, 32'hFF000000, 0,    0);
    add(8'h06, 1'b0, 24'h0,  0, 0, 32'h0,        0, 32'h0,        0,    1);
    add(8'h02, 1'b1, 24'h30, 1, 5, 32'h0F000000, 0, 32'h0,        64,   0);
    add(8'h06, 1'b0, 24'h0,  0, 0, 32'h0,        0, 32'h0,        0,    1);
    add(8'h02, 1'b1, 24'h40, 0, 5, 32'h0,        0, 32'h0,        0,    1);
    add(8'h03, 1'b1, 24'h30, 2, 0, 32'h0,        1, 32'h0FFF0000, 0,    1);
    add(8'h03, 1'b1, 24'h40, 1, 0, 32'h0,        1, 32'hFF000000, 0,    1);
    add(8'hC7, 1'b0, 24'h0,  0, 0, 32'h0,        0, 32'h0,        -2,   1);

    rst       = 1'b1;
    spi.SCK   = 1'b0;
    spi.CSbar = 1'b1;
    spi.DI    = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset DO", {31'h0, spi.DO}, 32'h0);
    check("reset busy", {31'h0, busy}, 32'h0);
    check("reset wel", {31'h0, wel}, 32'h0);
    check("reset last_cmd", {24'h0, last_cmd}, 32'h0);

    for (int i = 0; i < vq.size(); i++) run_vec(vq[i], i);

    // Last vector left a chip erase running: reset must drop busy and wel at once.
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("erase rst busy", {31'h0, busy}, 32'h0);
    check("erase rst wel", {31'h0, wel}, 32'h0);
    check("erase rst DO", {31'h0, spi.DO}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("erase rst busy stays low", {31'h0, busy}, 32'h0);

    // Reset in the middle of an ID read while DO is driving a 1.
    spi.CSbar = 1'b0;
    repeat (4) @(negedge clk);
    send_byte(8'h9F, r);
    repeat (4) @(negedge clk);
    check("id first bit", {31'h0, spi.DO}, 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("xfer rst DO", {31'h0, spi.DO}, 32'h0);
    check("xfer rst last_cmd", {24'h0, last_cmd}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    spi.CSbar = 1'b1;
    repeat (10) @(negedge clk);

    fin = vq[0];
    run_vec(fin, 99);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
